// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared processor-wide definitions used by the instruction encoder and the
// instruction field decoder.
//   - FMT_* : 2-bit instruction format selector codes (R, I, J, illegal)
//   - *_MSB/*_LSB : bit positions of the MIPS instruction fields
//   - enc_state_e : encoder session state (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

    // Format selector codes.
    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_J   = 2'b10;
    localparam logic [1:0] FMT_BAD = 2'b11;

    // Field positions within a 32-bit instruction word. The decoder slices
    // with the same constants, so an encoded word always decodes back to its
    // fields.
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;

    // Encoder load-session state.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } enc_state_e;

endpackage

// File: rtl/instr_encoder_field_pack.sv
// -----------------------------------------------------------------------------
// instr_field_pack
// Purely combinational packer that turns a format selector plus the MIPS
// instruction fields into a 32-bit instruction word.
// Ports:
//   fmt_i          format selector (R/I/J/illegal)
//   opcode_i       instruction[31:26]
//   rs_i, rt_i     register fields
//   rd_i, shamt_i  R-type only
//   func_i         R-type only
//   immediate_i    I-type only
//   jump_addr_i    J-type only
//   word_o         packed instruction (0 when the format is illegal)
//   illegal_o      high when fmt_i is the illegal code
// -----------------------------------------------------------------------------
module instr_field_pack
    import instr_encoder_pkg::*;
(
    input  logic [1:0]  fmt_i,
    input  logic [5:0]  opcode_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  func_i,
    input  logic [15:0] immediate_i,
    input  logic [25:0] jump_addr_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    // Select the packing by format. Fields a format does not use are simply
    // not routed, so whatever the source leaves on them has no effect.
    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (fmt_i)
            FMT_R: begin
                word_o[OPC_MSB:OPC_LSB]        = opcode_i;
                word_o[RS_LSB+4:RS_LSB]        = rs_i;
                word_o[RT_LSB+4:RT_LSB]        = rt_i;
                word_o[RD_LSB+4:RD_LSB]        = rd_i;
                word_o[SHAMT_LSB+4:SHAMT_LSB]  = shamt_i;
                word_o[SHAMT_LSB-1:0]          = func_i;
            end
            FMT_I: begin
                word_o[OPC_MSB:OPC_LSB]        = opcode_i;
                word_o[RS_LSB+4:RS_LSB]        = rs_i;
                word_o[RT_LSB+4:RT_LSB]        = rt_i;
                word_o[RT_LSB-1:0]             = immediate_i;
            end
            FMT_J: begin
                word_o[OPC_MSB:OPC_LSB]        = opcode_i;
                word_o[OPC_LSB-1:0]            = jump_addr_i;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Accepts MIPS instruction fields over a valid/ready handshake, packs them into
// 32-bit R/I/J words and streams them into the instruction memory write port
// at consecutive addresses starting at BASE_ADDR.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             begin a load session (honoured in IDLE or DONE)
//   in_valid/in_ready field tuple handshake
//   fmt .. last       field tuple (format, fields, end-of-program marker)
//   mem_we/addr/wdata instruction memory write port (one-cycle strobe)
//   busy, done        session status (RUN / DONE)
//   err               sticky illegal-format or overflow flag
//   word_count        words written in the current session
// -----------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        func,
    input  logic [15:0]       immediate,
    input  logic [25:0]       jump_address,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0]       packedWord;
    logic              packedIllegal;
    logic              accept;
    logic              atTop;

    instr_field_pack u_pack (
        .fmt_i       (fmt),
        .opcode_i    (opcode),
        .rs_i        (rs),
        .rt_i        (rt),
        .rd_i        (rd),
        .shamt_i     (shamt),
        .func_i      (func),
        .immediate_i (immediate),
        .jump_addr_i (jump_address),
        .word_o      (packedWord),
        .illegal_o   (packedIllegal)
    );

    assign accept = in_valid && (state_q == RUN);
    assign atTop  = (addr_q == ADDR_TOP);

    // Next-state logic. A legal accept registers the write for the following
    // cycle together with the address/count update, so the strobe, the new
    // word_count and (for a final tuple) DONE all become visible at once.
    // At the top address the pointer is frozen rather than wrapped: the block
    // leaves RUN on that accept, so no further write can use it.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    addr_d  = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (packedIllegal) begin
                        err_d = 1'b1;
                        if (last) begin
                            state_d = DONE;
                        end
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wdata_d = packedWord;
                        count_d = count_q + 1'b1;
                        if (!atTop) begin
                            addr_d = addr_q + 1'b1;
                        end
                        if (last) begin
                            state_d = DONE;
                        end else if (atTop) begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset wins over a same-edge accept, which
    // is what cancels a pending write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready   = (state_q == RUN);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign word_count = count_q;
    assign mem_we     = we_q;
    assign mem_addr   = waddr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Scoreboard bench for instr_encoder. A small session model predicts each
// write and queues it; a monitor pops and compares whenever mem_we is seen,
// and decodes the written word back into fields for a round-trip check.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int AW   = 3;
    localparam int BASE = 4;
    localparam int TOP  = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    fmt = 2'b00;
    logic [5:0]    opcode = '0;
    logic [4:0]    rs = '0;
    logic [4:0]    rt = '0;
    logic [4:0]    rd = '0;
    logic [4:0]    shamt = '0;
    logic [5:0]    func = '0;
    logic [15:0]   immediate = '0;
    logic [25:0]   jump_address = '0;
    logic          last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    typedef struct {
        int          addr;
        logic [31:0] word;
        int          wc;
        bit          dn;
        bit          er;
        logic [1:0]  f;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] im;
        logic [25:0] ja;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Session model: 0 = idle, 1 = running, 2 = finished.
    int          mState = 0;
    int          mCount = 0;
    bit          mErr = 1'b0;
    int          mLastAddr = 0;
    logic [31:0] mLastData = '0;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fmt          (fmt),
        .opcode       (opcode),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .shamt        (shamt),
        .func         (func),
        .immediate    (immediate),
        .jump_address (jump_address),
        .last         (last),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .word_count   (word_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing from the field layout, using plain shifts and sums.
    function automatic logic [31:0] refPack(input logic [1:0] f);
        logic [31:0] w;
        w = 32'(opcode) * 32'h0400_0000;
        case (f)
            2'd0: w = w + 32'(rs) * 32'h20_0000 + 32'(rt) * 32'h1_0000
                        + 32'(rd) * 32'h800 + 32'(shamt) * 32'h40 + 32'(func);
            2'd1: w = w + 32'(rs) * 32'h20_0000 + 32'(rt) * 32'h1_0000 + 32'(immediate);
            2'd2: w = w + 32'(jump_address);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Status outputs are compared once per cycle against the session model.
    task automatic checkOutput();
        check("in_ready",   32'(in_ready),   32'(mState == 1));
        check("busy",       32'(busy),       32'(mState == 1));
        check("done",       32'(done),       32'(mState == 2));
        check("err",        32'(err),        32'(mErr));
        check("word_count", 32'(word_count), 32'(mCount));
        check("mem_addr",   32'(mem_addr),   32'(mLastAddr));
        check("mem_wdata",  mem_wdata,       mLastData);
    endtask

    // Advances the session model by one clock edge using the driven inputs,
    // queuing the write the DUT is expected to present next cycle.
    task automatic modelStep();
        exp_t e;
        int   a;
        if (reset) begin
            mState = 0; mCount = 0; mErr = 1'b0; mLastAddr = 0; mLastData = '0;
        end else if (start && mState != 1) begin
            mState = 1; mCount = 0; mErr = 1'b0;
        end else if (in_valid && mState == 1) begin
            a = BASE + mCount;
            if (fmt == 2'd3) begin
                mErr = 1'b1;
                if (last) mState = 2;
            end else begin
                mCount++;
                mLastAddr = a;
                mLastData = refPack(fmt);
                if (last) mState = 2;
                else if (a == TOP) begin
                    mState = 2;
                    mErr = 1'b1;
                end
                e.addr = a; e.word = mLastData; e.wc = mCount;
                e.dn = (mState == 2); e.er = mErr; e.f = fmt;
                e.op = opcode; e.rs = rs; e.rt = rt; e.rd = rd; e.sh = shamt;
                e.fn = func; e.im = immediate; e.ja = jump_address;
                sb.push_back(e);
            end
        end
    endtask

    task automatic randFields();
        opcode = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom);
        rd = 5'($urandom); shamt = 5'($urandom); func = 6'($urandom);
        immediate = 16'($urandom); jump_address = 26'($urandom);
    endtask

    // Drives one cycle of inputs at the falling edge after checking status.
    task automatic applyStimulus(input bit r, input bit s, input bit v,
                                 input logic [1:0] f, input bit l);
        checkOutput();
        reset = r; start = s; in_valid = v; fmt = f; last = l;
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every write strobe must match the head of the scoreboard and
    // decode back to the fields it was built from; a queued write with no
    // strobe is a missing write.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                check("wr_addr",  32'(mem_addr),   32'(e.addr));
                check("wr_data",  mem_wdata,       e.word);
                check("wr_count", 32'(word_count), 32'(e.wc));
                check("wr_done",  32'(done),       32'(e.dn));
                check("wr_err",   32'(err),        32'(e.er));
                check("rt_opcode", 32'(mem_wdata >> 26), 32'(e.op));
                if (e.f == 2'd2) begin
                    check("rt_jaddr", mem_wdata & 32'h03FF_FFFF, 32'(e.ja));
                end else begin
                    check("rt_rs", (mem_wdata >> 21) & 32'h1F, 32'(e.rs));
                    check("rt_rt", (mem_wdata >> 16) & 32'h1F, 32'(e.rt));
                    if (e.f == 2'd1) begin
                        check("rt_imm", mem_wdata & 32'hFFFF, 32'(e.im));
                    end else begin
                        check("rt_rd",    (mem_wdata >> 11) & 32'h1F, 32'(e.rd));
                        check("rt_shamt", (mem_wdata >> 6) & 32'h1F,  32'(e.sh));
                        check("rt_func",  mem_wdata & 32'h3F,         32'(e.fn));
                    end
                end
            end
        end else if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing_write: got mem_we 0, expected write addr %0h data %0h", e.addr, e.word);
        end
    end

    // Directed sessions from the test plan followed by a randomized soak.
    initial begin
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1, 0, 0, 2'd0, 0);
        applyStimulus(0, 0, 0, 2'd0, 0);

        // R, I, J words back to back at BASE, BASE+1, BASE+2.
        applyStimulus(0, 1, 0, 2'd0, 0);
        randFields(); opcode = 6'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; func = 6'h20;
        applyStimulus(0, 0, 1, 2'd0, 0);
        randFields(); opcode = 6'd8; rs = 5'd1; rt = 5'd2; immediate = 16'hFFFF;
        applyStimulus(0, 0, 1, 2'd1, 0);
        randFields(); opcode = 6'd2; jump_address = 26'h40;
        applyStimulus(0, 0, 1, 2'd2, 1);
        applyStimulus(0, 0, 0, 2'd0, 0);

        // Illegal format in the middle; err sticks through DONE until restart.
        applyStimulus(0, 1, 0, 2'd0, 0);
        randFields(); applyStimulus(0, 0, 1, 2'd0, 0);
        randFields(); applyStimulus(0, 0, 1, 2'd3, 0);
        randFields(); applyStimulus(0, 0, 1, 2'd1, 1);
        applyStimulus(0, 0, 0, 2'd0, 0);
        applyStimulus(0, 1, 0, 2'd0, 0);

        // Overflow: more tuples than capacity with no last, valid held high.
        for (int i = 0; i < 6; i++) begin
            randFields();
            applyStimulus(0, 0, 1, 2'(i % 3), 0);
        end

        // Final slot filled by a tuple marked last: DONE without err.
        applyStimulus(0, 1, 0, 2'd0, 0);
        for (int i = 0; i < 4; i++) begin
            randFields();
            applyStimulus(0, 0, 1, 2'(i % 3), (i == 3));
        end

        // Reset on the cycle of an accept cancels the write.
        applyStimulus(0, 1, 0, 2'd0, 0);
        randFields(); applyStimulus(0, 0, 1, 2'd0, 0);
        randFields(); applyStimulus(1, 0, 1, 2'd1, 0);
        applyStimulus(0, 0, 0, 2'd0, 0);

        // Randomized soak including stray starts and occasional resets.
        for (int i = 0; i < 800; i++) begin
            randFields();
            applyStimulus(($urandom_range(99) == 0),
                          ($urandom_range(14) == 0),
                          ($urandom_range(3) != 0),
                          ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2)),
                          ($urandom_range(9) == 0));
        end

        applyStimulus(0, 0, 0, 2'd0, 0);
        applyStimulus(0, 0, 0, 2'd0, 0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
